// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the read side of the 16-entry addressable
// fifo store.
//   DATA_W  : width of one stored entry
//   ADDR_W  : width of the store read address
//   DEPTH   : number of store entries (2**ADDR_W)
//   state_t : read FSM encoding (IDLE -> LOAD -> HOLD)
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // nothing presented; store read of rd_ptr in flight
    ST_LOAD = 2'd1,  // store data_out is valid this cycle, capture it
    ST_HOLD = 2'd2   // entry presented downstream until popped
  } state_t;

endpackage

// File: rtl/fifo_occ_counter.sv
// ----------------------------------------------------------------------------
// fifo_occ_counter
// Occupancy tracking for the fifo read side: keeps a private copy of the
// writer pointer, the read pointer and the entry count, and derives the
// empty / full / sticky overflow flags.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   wr_en    in   writer committed one entry this cycle
//   pop      in   downstream accepted the presented entry this cycle
//   flush    in   discard everything buffered (rd_ptr jumps to wr_ptr)
//   rd_ptr   out  current read pointer
//   count    out  entries written and not yet popped, 0..DEPTH
//   empty    out  count == 0
//   full     out  count == DEPTH
//   overflow out  sticky, set by a write into a full store with no pop
// ----------------------------------------------------------------------------
module fifo_occ_counter #(
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int DEPTH  = fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic [ADDR_W-1:0] w_wr_ptr_next;
  logic [ADDR_W-1:0] w_rd_ptr_next;
  logic [ADDR_W:0]   w_count_next;
  logic              w_overflow_next;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // The writer pointer advances on every commit, even into a full store:
  // the writer itself does not stall, so its pointer must keep moving.
  assign w_wr_ptr_next = wr_en ? (r_wr_ptr + 1'b1) : r_wr_ptr;

  always_comb begin
    w_rd_ptr_next   = r_rd_ptr;
    w_count_next    = r_count;
    w_overflow_next = r_overflow;
    if (flush) begin
      // Jump to the post-write pointer so a same-cycle commit is discarded too.
      w_rd_ptr_next   = w_wr_ptr_next;
      w_count_next    = '0;
      w_overflow_next = 1'b0;
    end else begin
      if (pop) begin
        w_rd_ptr_next = r_rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        if (w_full) begin
          // Oldest entry gets overwritten; occupancy saturates at DEPTH.
          w_overflow_next = 1'b1;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end else if (pop && !wr_en && !w_empty) begin
        w_count_next = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign rd_ptr   = r_rd_ptr;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: rtl/fifo_reader.sv
// ----------------------------------------------------------------------------
// fifo_reader
// Read-side controller for the addressable fifo store. Turns the store's
// address-indexed, 1-cycle registered read port into an in-order
// valid/ready stream.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   wr_en        in   writer committed one entry this cycle
//   flush        in   discard all buffered entries
//   mem_rdata    in   store data_out, valid one cycle after read_address
//   read_address out  store read address (always the read pointer)
//   out_data     out  entry presented downstream
//   out_valid    out  out_data holds a valid entry
//   out_ready    in   consumer accepts out_data when out_valid is high
//   count        out  buffered entries, 0..DEPTH
//   empty        out  count == 0
//   full         out  count == DEPTH
//   overflow     out  sticky, write while full
// ----------------------------------------------------------------------------
module fifo_reader #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int DEPTH  = fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  import fifo_pkg::*;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] w_out_data_next;
  logic              r_out_valid;
  logic              w_out_valid_next;

  logic              w_pop;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic [ADDR_W:0]   w_count;

  // out_ready while nothing is presented has no effect.
  assign w_pop = r_out_valid && out_ready;

  fifo_occ_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_occ (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .pop      (w_pop),
    .flush    (flush),
    .rd_ptr   (w_rd_ptr),
    .count    (w_count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always_comb begin
    w_state_next     = r_state;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    if (flush) begin
      // Presented data is dropped but out_data keeps its last value.
      w_state_next     = ST_IDLE;
      w_out_valid_next = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // read_address already shows rd_ptr, so the store read issued at
          // the edge leaving IDLE lands on mem_rdata during LOAD.
          w_out_valid_next = 1'b0;
          if (w_count != '0) begin
            w_state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_out_data_next  = mem_rdata;
          w_out_valid_next = 1'b1;
          w_state_next     = ST_HOLD;
        end
        ST_HOLD: begin
          w_out_valid_next = 1'b1;
          if (w_pop) begin
            w_out_valid_next = 1'b0;
            w_state_next     = ST_IDLE;
          end
        end
        default: begin
          w_out_valid_next = 1'b0;
          w_state_next     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  assign read_address = w_rd_ptr;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign count        = w_count;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       flush;
  logic       out_ready;
  logic [7:0] wr_data;
  logic [7:0] mem_rdata;
  logic [3:0] read_address;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  always #5 clk = ~clk;

  fifo_reader dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .read_address (read_address),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  // Store model: 16x8, written at the writer pointer, registered read.
  logic [7:0] mem [16];
  logic [3:0] tb_wp;

  always @(posedge clk) begin
    mem_rdata <= mem[read_address];
    if (rst && wr_en) mem[tb_wp] <= wr_data;
    if (!rst) tb_wp <= 4'd0;
    else if (wr_en) tb_wp <= tb_wp + 4'd1;
  end

  int n_vec = 0;
  int n_err = 0;

  // Pop scoreboard used by the hand-written stream sequences.
  bit         chk_pops = 1'b0;
  logic [7:0] exp_q[$];
  logic [3:0] tb_rp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    if (chk_pops && rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got data 0x%0h, want no pop", out_data);
      end else begin
        e = exp_q.pop_front();
        $display("pop data=%02h addr=%0d", out_data, read_address);
        chk("pop_data", out_data, e);
        chk("pop_addr", read_address, tb_rp);
        tb_rp = tb_rp + 4'd1;
      end
    end
    if (chk_pops && rst && !flush && wr_en) exp_q.push_back(wr_data);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] wd;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic [3:0] ea;
    logic       eo;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [7:0] wd, logic rdy,
                              logic ev, logic [7:0] ed, logic [4:0] ec,
                              logic [3:0] ea, logic eo);
    vec_t v;
    v.r = r; v.w = w; v.wd = wd; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ea = ea; v.eo = eo;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst = 1'b0; wr_en = 1'b0; flush = 1'b0; out_ready = 1'b0; wr_data = 8'h00;
    tb_rp = 4'd0;

    // Reset held with wr_en high, then release.
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 1, 8'hAA, 1, 0, 8'h00, 5'd0, 4'd0, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd0, 4'd0, 0));
    // In-order stream, out_ready high: valid 3 cycles after first write.
    vt.push_back(mk(1, 1, 8'h24, 1, 0, 8'h00, 5'd1, 4'd0, 0));
    vt.push_back(mk(1, 1, 8'h81, 1, 0, 8'h00, 5'd2, 4'd0, 0));
    vt.push_back(mk(1, 1, 8'h09, 1, 1, 8'h24, 5'd3, 4'd0, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd2, 4'd1, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd2, 4'd1, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 1, 8'h81, 5'd2, 4'd1, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd1, 4'd2, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd1, 4'd2, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 1, 8'h09, 5'd1, 4'd2, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd0, 4'd3, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd0, 4'd3, 0));
    // Backpressure: one entry held for 10 cycles, then exactly one pop.
    vt.push_back(mk(1, 1, 8'h63, 0, 0, 8'h00, 5'd1, 4'd3, 0));
    vt.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 5'd1, 4'd3, 0));
    vt.push_back(mk(1, 0, 8'h00, 0, 1, 8'h63, 5'd1, 4'd3, 0));
    for (int i = 0; i < 10; i++) vt.push_back(mk(1, 0, 8'h00, 0, 1, 8'h63, 5'd1, 4'd3, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd0, 4'd4, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 5'd0, 4'd4, 0));

    foreach (vt[i]) begin
      rst = vt[i].r; wr_en = vt[i].w; wr_data = vt[i].wd; out_ready = vt[i].rdy;
      tick();
      $display("vec %0d: valid=%0b data=%02h count=%0d addr=%0d", i, out_valid, out_data, count, read_address);
      chk($sformatf("v%0d_valid", i), out_valid, vt[i].ev);
      if (vt[i].ev) chk($sformatf("v%0d_data", i), out_data, vt[i].ed);
      chk($sformatf("v%0d_count", i), count, vt[i].ec);
      chk($sformatf("v%0d_empty", i), empty, vt[i].ec == 5'd0);
      chk($sformatf("v%0d_full", i), full, vt[i].ec == 5'd16);
      chk($sformatf("v%0d_ovf", i), overflow, vt[i].eo);
      chk($sformatf("v%0d_addr", i), read_address, vt[i].ea);
    end

    // Full / overflow: 16 writes with no pops (pointers start at 4).
    rst = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    $display("full: count=%0d full=%0b ovf=%0b", count, full, overflow);
    chk("full_count", count, 5'd16);
    chk("full_flag", full, 1'b1);
    chk("full_empty", empty, 1'b0);
    chk("full_ovf", overflow, 1'b0);
    chk("full_valid", out_valid, 1'b1);
    chk("full_data", out_data, 8'h10);
    // Same-cycle write and pop at full: count holds, no overflow.
    wr_en = 1'b1; wr_data = 8'h20; out_ready = 1'b1;
    tick();
    chk("wrpop_count", count, 5'd16);
    chk("wrpop_ovf", overflow, 1'b0);
    chk("wrpop_valid", out_valid, 1'b0);
    // Write into full with no pop.
    wr_en = 1'b1; wr_data = 8'h21; out_ready = 1'b0;
    tick();
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_count", count, 5'd16);
    chk("ovf_full", full, 1'b1);
    wr_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_count", count, 5'd0);
    chk("flush1_ovf", overflow, 1'b0);
    chk("flush1_addr", read_address, 4'd6);

    // Wrap: restart from pointer 0, stream 15 entries, then two across the wrap.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst2_addr", read_address, 4'd0);
    tb_rp = 4'd0; exp_q.delete(); chk_pops = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'(i * 7 + 3);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain1_left", exp_q.size(), 0);
    chk("drain1_addr", read_address, 4'd15);
    chk("drain1_count", count, 5'd0);
    wr_en = 1'b1; wr_data = 8'h0d;
    tick();
    wr_data = 8'h8d;
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain2_left", exp_q.size(), 0);
    chk("drain2_addr", read_address, 4'd1);
    chk("drain2_count", count, 5'd0);
    chk_pops = 1'b0;

    // Flush in HOLD with count=5 (writer pointer 1 -> 6).
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("hold5_valid", out_valid, 1'b1);
    chk("hold5_count", count, 5'd5);
    chk("hold5_data", out_data, 8'h50);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2_valid", out_valid, 1'b0);
    chk("flush2_count", count, 5'd0);
    chk("flush2_empty", empty, 1'b1);
    chk("flush2_addr", read_address, 4'd6);
    chk("flush2_data", out_data, 8'h50);
    // Flush coinciding with a write discards that write too (pointer 8 -> 9).
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    flush = 1'b1; wr_data = 8'h62;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush3_addr", read_address, 4'd9);
    chk("flush3_count", count, 5'd0);
    tick();
    chk("flush3_idle_valid", out_valid, 1'b0);
    chk("flush3_idle_count", count, 5'd0);

    // Reset during HOLD.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h70 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("hold3_valid", out_valid, 1'b1);
    chk("hold3_data", out_data, 8'h70);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst3_valid", out_valid, 1'b0);
    chk("rst3_data", out_data, 8'h00);
    chk("rst3_count", count, 5'd0);
    chk("rst3_empty", empty, 1'b1);
    chk("rst3_full", full, 1'b0);
    chk("rst3_ovf", overflow, 1'b0);
    chk("rst3_addr", read_address, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side controller for the 16-entry addressable fifo store. It tracks occupancy from the writer's commit strobe and drives the store's read_address. It captures the store's registered read data and presents each entry downstream on a valid/ready handshake.
- Sits between the fifo store's data_out and the consumer. It turns the store's raw address-indexed read port into an in-order stream.

Parameters:
- DATA_W, 8, width of one stored entry
- ADDR_W, 4, width of read_address
- DEPTH, 16, number of store entries; must equal 2**ADDR_W

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-low reset
- wr_en  input  1  writer committed one entry to the store this cycle, at the writer pointer
- flush  input  1  synchronous discard of all buffered entries
- mem_rdata  input  DATA_W  store data_out; valid the cycle after read_address is presented (1-cycle registered read)
- read_address  output  ADDR_W  store read address; always equals internal rd_ptr
- out_data  output  DATA_W  entry presented downstream
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  consumer accepts out_data when out_valid is also high
- count  output  ADDR_W+1  entries written and not yet popped, range 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overflow  output  1  sticky; set by wr_en while full

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; rd_ptr=0; wr_ptr=0; read_address=0; out_data=0; out_valid=0; count=0; overflow=0. This forces empty=1 and full=0. Reset overrides every other input, including in mid-transfer.
- Priority order: reset > flush > normal operation.
- wr_ptr:
  - Internal copy of the writer pointer.
  - Increments modulo DEPTH on every wr_en, including when full.
- Pop: defined as out_valid && out_ready at an edge. On a pop, rd_ptr increments modulo DEPTH, with wrap 15->0.
- count update:
  - Increments on wr_en alone.
  - Decrements on pop alone.
  - Unchanged when wr_en and pop occur together.
- Overflow: wr_en with count==DEPTH and no pop in the same cycle:
  - overflow<=1;
  - count stays DEPTH;
  - the oldest entry is overwritten, so its data is undefined.
- FSM state IDLE:
  - out_valid=0.
  - If count!=0, go to LOAD.
  - read_address is already rd_ptr, so the store read is in flight.
- FSM state LOAD:
  - out_data<=mem_rdata;
  - out_valid<=1;
  - go to HOLD.
- FSM state HOLD:
  - out_valid=1.
  - out_data is held stable until the pop.
  - On a pop: out_valid<=0, go to IDLE.
  - Otherwise stay in HOLD.
- Latency: a wr_en in cycle N into an empty block gives out_valid=1 in cycle N+3.
- Throughput: at most 1 entry per 3 cycles with out_ready held high.
- flush:
  - rd_ptr<=wr_ptr, including a wr_en in the same cycle; that entry is discarded.
  - count<=0; out_valid<=0; overflow<=0; state<=IDLE.
  - out_data is left unchanged.
- out_ready high while out_valid is low: ignored.
- Arithmetic: all pointer arithmetic is unsigned with natural ADDR_W wrap. count is ADDR_W+1 bits and never exceeds DEPTH.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W, ADDR_W, DEPTH;
  - the 2-bit FSM state encoding IDLE=0, LOAD=1, HOLD=2.
- One sub-module, fifo_occ_counter, is natural. It contains the wr_ptr, rd_ptr and count registers plus the full/empty/overflow logic, with inputs wr_en, pop and flush.
- The FSM and the output register stay in fifo_reader.

Test Plan:
- The bench models the store as a 16x8 memory, written at wr_ptr on wr_en, with a registered read on read_address.
1. Reset: hold rst=0 for 3 cycles with wr_en=1 -> out_valid=0, count=0, empty=1, full=0, overflow=0, read_address=0. Deassert rst -> still idle.
2. In-order stream: wr_en with data 0x24, 0x81, 0x09 in consecutive cycles, out_ready=1 -> out_valid first high 3 cycles after the first wr_en. out_data is 0x24, 0x81, 0x09 in order. read_address steps 0, 1, 2, 3. Final count=0.
3. Backpressure: one entry 0x63, out_ready=0 for 10 cycles -> out_valid stays 1, out_data stays 0x63, count=1. Raise out_ready -> exactly one pop, count=0.
4. Full/overflow: 16 wr_en with no pops -> full=1, count=16. 17th wr_en -> overflow=1, count=16. Same-cycle wr_en and pop at full -> count stays 16, no new overflow.
5. Wrap: write and drain 15 entries, then write 0x0d, 0x8d -> read_address goes 15 then 0. out_data is 0x0d then 0x8d.
6. Mid-operation events: flush while in HOLD with count=5 -> next cycle out_valid=0, count=0, read_address=wr_ptr. Separately, rst=0 during HOLD -> all outputs return to the reset values at the next edge.
